icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped instruction cache; the responder the instruction fetcher talks to.
//  Fetcher presents a pc with its ready flag; a hit returns the word in the same cycle.
//  A miss fetches one 32-bit word from the memory controller with a req/arrived handshake, fills the line, then hits.
//  Sits between the fetcher (IF) and the memory controller (MC).
// PARAMETERS
//  INDEX_WIDTH  8   log2(number of lines); one 32-bit word per line; index = pc[INDEX_WIDTH+1:2]
//  TAG_WIDTH    30-INDEX_WIDTH (derived, localparam)  tag = pc[31:INDEX_WIDTH+2]
// PORTS
//  clk               in   1   clock, single domain
//  rst               in   1   synchronous, active-high reset
//  rdy               in   1   global enable; 0 = pause, all state frozen
//  rdy_from_if       in   1   fetcher requests the instruction at pc_from_if
//  pc_from_if        in   32  fetch address; pc[1:0] ignored
//  clear             in   1   fetcher rollback; discard any response owed for the current miss
//  instr_valid       out  1   instr_2if holds the word at pc_from_if this cycle
//  instr_2if         out  32  instruction data
//  req_2mc           out  1   miss request to memory controller (registered)
//  addr_2mc          out  32  word address of miss, {pc[31:2],2'b00} (registered)
//  instr_mc_arrived  in   1   MC returns requested word this cycle
//  instr_from_mc     in   32  returned word
// BEHAVIOUR
//  Storage: valid[2^INDEX_WIDTH], tag[], data[]; asynchronous read, write on posedge.
//  Reset (rst=1 at posedge): all valid bits 0, state IDLE, req_2mc=0, addr_2mc=0, drop=0.
//   Reset overrides rdy and aborts any miss in progress; a later arrived pulse is ignored because state is IDLE.
//  hit = valid[idx] & (tag[idx]==pc tag), combinational.
//  instr_valid = rdy & rdy_from_if & ~clear & (state==IDLE) & hit.
//   instr_2if = data[idx] when instr_valid is 1, otherwise 0.
//  Sequential updates happen only when rdy=1. When rdy=0, nothing changes and arrived is not sampled.
//  FSM:
//   IDLE: if rdy_from_if & ~clear & ~hit -> MISS.
//    Set req_2mc<=1, addr_2mc<={pc[31:2],2'b00}, latch miss index/tag, drop<=0.
//   MISS: req_2mc and addr_2mc are held stable until instr_mc_arrived=1 is sampled.
//    On arrival: write valid/tag/data at the latched index (even if drop=1; the data is true memory content).
//    Also on arrival: req_2mc<=0, go to IDLE.
//    clear=1 in MISS sets drop<=1. The fill still completes, and no instr_valid is produced for it.
//    If clear and arrived coincide, the line is filled and state goes to IDLE.
//    instr_mc_arrived while in IDLE is ignored.
//  Latency: hit 0 cycles (combinational).
//   Miss: req_2mc rises 1 cycle after the miss is seen; instr_valid for that pc comes 1 cycle after the arrived cycle.
//  Responses are never duplicated. The fetcher advances pc on the instr_valid cycle, so the next cycle looks up the new pc.
//  pc changes while in MISS (without clear) are served only after returning to IDLE; the stale fill is still written.
//  Conflict: same index, different tag -> miss; the fill overwrites (evicts) the old line.
//  Only one outstanding MC request; no prefetch, no write path (instruction memory is read-only).
// TESTING
//  1. rst, then pc=0x0, rdy_from_if=1 -> instr_valid=0; next cycle req_2mc=1, addr_2mc=0x0.
//     MC arrived=1 with 0x00000013 three cycles later -> req_2mc=0 next cycle, and instr_valid=1, instr_2if=0x00000013.
//  2. After filling 0x0 and 0x4, present pc=0x0 then 0x4 -> instr_valid=1 in both cycles with the stored words, req_2mc stays 0.
//  3. With 0x0 cached, pc=0x400 (same index, INDEX_WIDTH=8) -> miss, fill 0xDEADBEEF.
//     Then pc=0x0 -> misses again (evicted), addr_2mc=0x0.
//  4. Miss on 0x8, clear=1 for one cycle while in MISS, pc->0x100, then arrived with 0xAAAA5555.
//     -> no instr_valid for 0x8; the next cycle misses on 0x100; a later pc=0x8 hits with 0xAAAA5555.
//  5. rdy=0 for 4 cycles during MISS -> req_2mc/addr_2mc unchanged, instr_valid=0; the handshake resumes when rdy=1.
//  6. rst=1 during MISS, then arrived pulse -> ignored; pc=0x8 misses again (valid cleared), req_2mc=1.

Source files
------------

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between the fetcher and the memory controller
module icache #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rdy_from_if,
  input  logic [31:0] pc_from_if,
  input  logic        clear,
  output logic        instr_valid,
  output logic [31:0] instr_2if,
  output logic        req_2mc,
  output logic [31:0] addr_2mc,
  input  logic        instr_mc_arrived,
  input  logic [31:0] instr_from_mc
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int LINES = 1 << INDEX_WIDTH;
  typedef enum logic {IDLE, MISS} state_t;
  state_t r_state, w_next;
  logic [LINES-1:0] r_valid;
  logic [TAG_WIDTH-1:0] r_tag [LINES];
  logic [31:0] r_data [LINES];
  logic r_req, r_drop;
  logic [31:0] r_addr;
  logic [INDEX_WIDTH-1:0] r_idx;
  logic [TAG_WIDTH-1:0] r_mtag;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic [TAG_WIDTH-1:0] w_tag;
  logic w_hit, w_fill, w_start, w_unused;
  assign w_idx = pc_from_if[INDEX_WIDTH+1:2];
  assign w_tag = pc_from_if[31:INDEX_WIDTH+2];
  assign w_hit = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_start = rdy & (r_state == IDLE) & (w_next == MISS);
  assign w_fill = rdy & (r_state == MISS) & instr_mc_arrived;
  // A dropped miss still fills the line; its response is suppressed by the pc having moved on
  assign instr_valid = rdy & rdy_from_if & ~clear & (r_state == IDLE) & w_hit;
  assign instr_2if = instr_valid ? r_data[w_idx] : 32'h0;
  assign req_2mc = r_req;
  assign addr_2mc = r_addr;
  assign w_unused = &{1'b0, pc_from_if[1:0], r_drop};
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (rdy_from_if & ~clear & ~w_hit) ? MISS : IDLE;
    else
      w_next = instr_mc_arrived ? IDLE : MISS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_addr <= 32'h0;
      r_drop <= 1'b0;
      r_idx <= '0;
      r_mtag <= '0;
    end else if (rdy) begin
      r_state <= w_next;
      if (w_start) begin
        r_req <= 1'b1;
        r_addr <= {pc_from_if[31:2], 2'b00};
        r_idx <= w_idx;
        r_mtag <= w_tag;
        r_drop <= 1'b0;
      end else if (r_state == MISS) begin
        r_req <= ~instr_mc_arrived;
        r_drop <= r_drop | clear;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst)
      r_valid <= '0;
    else if (w_fill)
      r_valid[r_idx] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (~rst & w_fill) begin
      r_tag[r_idx] <= r_mtag;
      r_data[r_idx] <= instr_from_mc;
    end
  end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scoreboard bench; expected fetch responses are queued by stimulus, popped by a monitor
module tb_icache;
  logic clk = 0, rst = 1, rdy = 1, rdy_from_if = 0, clear = 0, instr_mc_arrived = 0;
  logic [31:0] pc_from_if = 0, instr_from_mc = 0;
  logic instr_valid, req_2mc;
  logic [31:0] instr_2if, addr_2mc;
  logic [63:0] q [$];
  int total = 0, bad = 0;
  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rdy_from_if(rdy_from_if), .pc_from_if(pc_from_if),
    .clear(clear), .instr_valid(instr_valid), .instr_2if(instr_2if), .req_2mc(req_2mc),
    .addr_2mc(addr_2mc), .instr_mc_arrived(instr_mc_arrived), .instr_from_mc(instr_from_mc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (instr_valid) begin
      if (q.size() == 0) chk("unexpected_valid pc", pc_from_if, 32'hFFFFFFFF);
      else begin
        logic [63:0] e;
        e = q.pop_front();
        chk("resp_pc", pc_from_if, e[63:32]);
        chk("resp_data", instr_2if, e[31:0]);
      end
    end
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] data, input int wait_c);
    pc_from_if = pc; rdy_from_if = 1;
    step();
    chk("req_up", {31'b0, req_2mc}, 1);
    chk("miss_addr", addr_2mc, {pc[31:2], 2'b00});
    repeat (wait_c) begin
      step();
      chk("req_hold", {31'b0, req_2mc}, 1);
    end
    instr_mc_arrived = 1; instr_from_mc = data;
    step();
    instr_mc_arrived = 0;
    chk("req_down", {31'b0, req_2mc}, 0);
    q.push_back({pc, data});
    step();
    rdy_from_if = 0;
  endtask
  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] data);
    pc_from_if = pc; rdy_from_if = 1;
    q.push_back({pc, data});
    step();
    chk("hit_no_req", {31'b0, req_2mc}, 0);
    rdy_from_if = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(); step();
    rst = 0;
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_req", {31'b0, req_2mc}, 0);
    chk("rst_addr", addr_2mc, 0);
    // 1: cold miss on 0x0, arrival three cycles after request
    fetch_miss(32'h0, 32'h00000013, 2);
    // 2: fill 0x4, then back-to-back hits
    fetch_miss(32'h4, 32'h00100093, 1);
    pc_from_if = 32'h0; rdy_from_if = 1; q.push_back({32'h0, 32'h00000013});
    step();
    chk("b2b_req0", {31'b0, req_2mc}, 0);
    pc_from_if = 32'h4; q.push_back({32'h4, 32'h00100093});
    step();
    chk("b2b_req1", {31'b0, req_2mc}, 0);
    rdy_from_if = 0;
    // 3: conflict eviction
    fetch_miss(32'h400, 32'hDEADBEEF, 2);
    fetch_miss(32'h0, 32'h00000013, 1);
    fetch_hit(32'h4, 32'h00100093);
    // 4: clear during miss; fill still lands
    pc_from_if = 32'h8; rdy_from_if = 1;
    step();
    chk("clr_req", {31'b0, req_2mc}, 1);
    chk("clr_addr", addr_2mc, 32'h8);
    clear = 1; pc_from_if = 32'h100;
    step();
    clear = 0;
    chk("clr_hold_addr", addr_2mc, 32'h8);
    instr_mc_arrived = 1; instr_from_mc = 32'hAAAA5555;
    step();
    instr_mc_arrived = 0;
    chk("clr_req_down", {31'b0, req_2mc}, 0);
    fetch_miss(32'h100, 32'h44444444, 0);
    fetch_hit(32'h8, 32'hAAAA5555);
    // 5: rdy pause during miss, arrived ignored while paused
    pc_from_if = 32'hC; rdy_from_if = 1;
    step();
    chk("pause_req", {31'b0, req_2mc}, 1);
    rdy = 0; instr_mc_arrived = 1; instr_from_mc = 32'hBAD0BAD0;
    repeat (4) begin
      step();
      chk("pause_req_hold", {31'b0, req_2mc}, 1);
      chk("pause_addr_hold", addr_2mc, 32'hC);
      chk("pause_no_valid", {31'b0, instr_valid}, 0);
    end
    rdy = 1; instr_from_mc = 32'h22222222;
    step();
    instr_mc_arrived = 0;
    chk("pause_req_down", {31'b0, req_2mc}, 0);
    q.push_back({32'hC, 32'h22222222});
    step();
    rdy_from_if = 0;
    // 6: reset during miss, later arrival ignored
    pc_from_if = 32'h10; rdy_from_if = 1;
    step();
    chk("rmiss_req", {31'b0, req_2mc}, 1);
    rst = 1; rdy_from_if = 0;
    step();
    rst = 0;
    chk("rmiss_req_clr", {31'b0, req_2mc}, 0);
    chk("rmiss_addr_clr", addr_2mc, 0);
    instr_mc_arrived = 1; instr_from_mc = 32'h33333333;
    step();
    instr_mc_arrived = 0;
    chk("rmiss_ignored", {31'b0, req_2mc}, 0);
    fetch_miss(32'h8, 32'hAAAA5555, 1);
    fetch_miss(32'h10, 32'h55555555, 0);
    step();
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
